game_controller: RTL
====================

// Module: game_controller
// PURPOSE
//  Player-side driver for the guess-checker interface in the level game.
//  Converts debounced buttons and 4-bit switches into single-cycle submit and
//  next-level pulses toward the checker.
//  Samples the checker's 3-bit result code (000 idle, 010 correct, 001 wrong).
//  Tracks level, score and remaining tries, and ends the game on win or loss.
// PARAMETERS
//  NUM_LEVELS   10  levels per game; the checker wraps at the same count (<=16)
//  MAX_TRIES    3   wrong guesses allowed per level (1..3, TRY_W bits)
//  TRY_W        2   width of tries_left
//  HOLD_CYCLES  4   cycles to hold the correct result before auto-advance (>=1)
//  RESP_LAT     1   cycles from the submit pulse to the result sample (>=1)
// PORTS
//  clk         in   1      system clock, rising edge
//  reset       in   1      asynchronous, active-high reset
//  btn_submit  in   1      debounced submit button (level)
//  btn_next    in   1      debounced skip/next button (level)
//  sw_data     in   4      player guess switches
//  result      in   3      checker result code
//  submit      out  1      1-cycle pulse to the checker
//  next_level  out  1      1-cycle pulse to the checker
//  data        out  4      guess latched at submit; held stable until the next submit
//  level       out  4      current level index, 0..NUM_LEVELS-1
//  score       out  4      correct guesses, saturates at 15
//  tries_left  out  TRY_W  remaining wrong guesses on this level
//  busy        out  1      high unless the state is IDLE or OVER
//  win         out  1      sticky: last level solved
//  game_over   out  1      sticky: tries exhausted
//  proto_err   out  1      sticky: sampled result was neither 010 nor 001
// BEHAVIOUR
//  Reset values:
//   - submit=0, next_level=0, data=0, level=0, score=0
//   - tries_left=MAX_TRIES, busy=0, win=0, game_over=0, proto_err=0, state=IDLE
//  Edge detect: rise = btn & ~prev. Both prev registers reset to 1, so a button
//   held through reset release produces no pulse.
//  States: IDLE, WAIT_RES, SHOW, OVER.
//  IDLE:
//   - submit rise: data<=sw_data; submit=1 for exactly one cycle; go to WAIT_RES.
//   - next rise (no submit rise): next_level=1 for one cycle; level+1, wrapping
//     NUM_LEVELS-1 -> 0; tries_left<=MAX_TRIES; score unchanged; stay in IDLE.
//   - Both rises in the same cycle: submit wins and the next rise is dropped.
//  WAIT_RES:
//   - Buttons ignored. Sample result exactly RESP_LAT cycles after the submit
//     pulse cycle; a stale code before that is never used.
//   - 010: score+1 (saturating); go to SHOW.
//   - 001: tries_left-1. If it becomes 0, set game_over and go to OVER;
//     otherwise go to IDLE.
//   - other: set proto_err; go to IDLE; tries and score unchanged.
//  SHOW:
//   - Wait HOLD_CYCLES cycles.
//   - If level==NUM_LEVELS-1: set win, go to OVER, no next_level pulse, level
//     held.
//   - Else: next_level pulse, level+1, tries_left<=MAX_TRIES, go to IDLE.
//  OVER: all inputs ignored; outputs frozen; only reset exits.
//  submit and next_level are never high in the same cycle, and never high on
//   consecutive cycles.
//  Reset mid-operation (any state) returns to IDLE with reset values
//   immediately (asynchronous).
// TESTING
//  1. Assert reset with btn_submit held high, then release -> all outputs at
//     reset values; no submit pulse until the button is released and
//     re-pressed.
//  2. sw_data=0 at level 0, submit rise, result=010 one cycle later ->
//     submit high 1 cycle with data=0; score=1; HOLD_CYCLES cycles later a
//     1-cycle next_level pulse; level=1; tries_left=3.
//  3. Three guesses answered 001 -> tries_left 2, 1, 0; game_over=1 after the
//     third; further rises on either button produce no pulses.
//  4. Ten correct guesses -> level reaches 9; win=1 after the 10th with no
//     next_level pulse; score=10.
//  5. btn_submit and btn_next rise in the same cycle in IDLE -> only a submit
//     pulse; level unchanged. Next press at level 9 -> level wraps to 0.
//  6. result=000 at the sample cycle -> proto_err=1, state IDLE, tries
//     unchanged. Reset asserted during WAIT_RES -> proto_err=0, busy=0.

Source files
------------

// File: rtl/game_controller.sv
// Player-side driver for the level game's guess checker.
// Turns button edges into submit/next pulses and tracks level, score and tries.
module game_controller #(
    parameter int NUM_LEVELS  = 10,
    parameter int MAX_TRIES   = 3,
    parameter int TRY_W       = 2,
    parameter int HOLD_CYCLES = 4,
    parameter int RESP_LAT    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_submit,
    input  logic             btn_next,
    input  logic [3:0]       sw_data,
    input  logic [2:0]       result,
    output logic             submit,
    output logic             next_level,
    output logic [3:0]       data,
    output logic [3:0]       level,
    output logic [3:0]       score,
    output logic [TRY_W-1:0] tries_left,
    output logic             busy,
    output logic             win,
    output logic             game_over,
    output logic             proto_err
);

    localparam int CMAX = (HOLD_CYCLES > RESP_LAT) ? HOLD_CYCLES : RESP_LAT;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [3:0]       LVL_LAST = 4'(NUM_LEVELS - 1);
    localparam logic [TRY_W-1:0] TRY_MAX  = TRY_W'(MAX_TRIES);
    localparam logic [TRY_W-1:0] TRY_ONE  = TRY_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SHOW, S_OVER} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic             sub_prev_q;
    logic             nxt_prev_q;
    logic             submit_q;
    logic             next_q;
    logic [3:0]       data_q;
    logic [3:0]       level_q;
    logic [3:0]       score_q;
    logic [TRY_W-1:0] tries_q;
    logic             win_q;
    logic             over_q;
    logic             perr_q;

    logic sub_rise;
    logic nxt_rise;

    assign sub_rise = btn_submit & ~sub_prev_q;
    assign nxt_rise = btn_next & ~nxt_prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            sub_prev_q <= 1'b1;
            nxt_prev_q <= 1'b1;
            submit_q   <= 1'b0;
            next_q     <= 1'b0;
            data_q     <= '0;
            level_q    <= '0;
            score_q    <= '0;
            tries_q    <= TRY_MAX;
            win_q      <= 1'b0;
            over_q     <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            sub_prev_q <= btn_submit;
            nxt_prev_q <= btn_next;
            submit_q   <= 1'b0;
            next_q     <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    // A rise landing right after a next pulse is dropped so
                    // the two pulses never sit on adjacent cycles.
                    if (!next_q) begin
                        if (sub_rise) begin
                            data_q   <= sw_data;
                            submit_q <= 1'b1;
                            cnt_q    <= CW'(RESP_LAT);
                            state_q  <= S_WAIT;
                        end else if (nxt_rise) begin
                            next_q  <= 1'b1;
                            level_q <= (level_q == LVL_LAST) ? 4'd0
                                                             : level_q + 4'd1;
                            tries_q <= TRY_MAX;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        unique case (result)
                            3'b010: begin
                                if (score_q != 4'hF) score_q <= score_q + 4'd1;
                                cnt_q   <= CW'(HOLD_CYCLES - 1);
                                state_q <= S_SHOW;
                            end
                            3'b001: begin
                                tries_q <= tries_q - TRY_ONE;
                                if (tries_q == TRY_ONE) begin
                                    over_q  <= 1'b1;
                                    state_q <= S_OVER;
                                end else begin
                                    state_q <= S_IDLE;
                                end
                            end
                            default: begin
                                perr_q  <= 1'b1;
                                state_q <= S_IDLE;
                            end
                        endcase
                    end
                end
                S_SHOW: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else if (level_q == LVL_LAST) begin
                        win_q   <= 1'b1;
                        state_q <= S_OVER;
                    end else begin
                        next_q  <= 1'b1;
                        level_q <= level_q + 4'd1;
                        tries_q <= TRY_MAX;
                        state_q <= S_IDLE;
                    end
                end
                S_OVER: begin
                end
            endcase
        end
    end

    assign submit     = submit_q;
    assign next_level = next_q;
    assign data       = data_q;
    assign level      = level_q;
    assign score      = score_q;
    assign tries_left = tries_q;
    assign busy       = (state_q == S_WAIT) || (state_q == S_SHOW);
    assign win        = win_q;
    assign game_over  = over_q;
    assign proto_err  = perr_q;

endmodule
